dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Memory-stage data-memory access unit. It sits directly downstream of instruction decode / EX and consumes the memory fields of the decoded control word (mem_read, mem_write, funct3) together with the ALU-computed address and the rs2 store data.
- It owns the data-cache handshake: generates byte enables, store-data lane shifting and load extraction / sign-extension, and produces the pipeline stall while an access is outstanding.

Parameters:
- MAX_WAIT, 255: cycles allowed in BUSY without data_resp before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  MEM-stage instruction valid
- mem_read  in  1  load request from control word
- mem_write  in  1  store request from control word
- funct3  in  3  load/store width code (lb/lh/lw/lbu/lhu; sb/sh/sw)
- addr  in  32  byte address (ALU output)
- store_data  in  32  rs2 value, unshifted
- flush  in  1  squash current MEM instruction
- stall  out  1  hold upstream pipeline
- load_data  out  32  aligned, extended load result
- load_valid  out  1  load_data valid this cycle
- misaligned  out  1  one-cycle trap pulse
- bus_error  out  1  one-cycle timeout pulse
- data_read  out  1  cache read strobe
- data_write  out  1  cache write strobe
- data_mbe  out  4  byte enables
- data_addr  out  32  word address, {addr[31:2],2'b00}
- data_wdata  out  32  lane-shifted store data
- data_rdata  in  32  cache read data
- data_resp  in  1  cache response, one cycle

Behaviour:
- Reset (async) forces IDLE. All outputs are 0 and the wait counter is 0, including when reset is asserted mid-BUSY; the pending cache transaction is abandoned.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start condition: req_valid & !flush & exactly one of mem_read/mem_write & aligned & legal funct3.
  - Latch addr, mbe, shifted wdata and funct3; go to BUSY.
  - stall = 1 combinationally in this cycle.
- IDLE, no memory operation, or flush: stall = 0; zero latency; stay in IDLE.
- Trap cases, all in IDLE: mem_read & mem_write both set; lw/sw with addr[1:0] != 0; lh/lhu/sh with addr[0] = 1; illegal funct3.
  - misaligned = 1 in the same cycle; no access issued; stall = 0.
- BUSY:
  - Registered data_read/data_write are held high with stable data_addr, data_mbe and data_wdata.
  - stall = 1.
  - Counter increments each cycle.
  - On data_resp: capture data_rdata, drop strobes next edge, go to DONE.
  - Counter reaching MAX_WAIT (when nonzero) without data_resp: drop strobes, set the error flag, go to DONE.
- DONE:
  - stall = 0 for exactly one cycle.
  - load_valid = 1 if the access was a load, not flushed, and not timed out.
  - bus_error = 1 if timed out.
  - Return to IDLE next cycle.
- Access latency: request in cycle 0 → strobes from cycle 1 → resp in cycle N → DONE in N+1. Minimum 2-cycle stall.
- flush during BUSY: the cache transaction runs to data_resp (no abort). The result is suppressed: load_valid stays 0.
- Byte enables, with addr[1:0] = o:
  - byte access: 4'b0001 << o
  - half access: addr[1] ? 4'b1100 : 4'b0011
  - word access: 4'b1111
- data_wdata = store_data << (8*o) for sb/sh; unchanged for sw.
- Load extract: byte = rdata[8*o +: 8]; half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend to 32; lbu/lhu zero-extend.
- Simultaneous data_resp and timeout in the same cycle: resp wins.
- data_resp outside BUSY is ignored.

Test Plan:
- lb, addr=0x1003, rdata=0x80112233, resp after 3 cycles → mbe=4'b1000, data_addr=0x1000, load_data=0xFFFFFF80, load_valid one cycle, stall 5 cycles.
- sh, addr=0x2002, store_data=0x0000BEEF → data_write=1, mbe=4'b1100, data_wdata=0xBEEF0000; no load_valid.
- lw, addr=0x3001 → misaligned pulse same cycle, data_read never asserted, stall=0.
- lhu, addr=0x4000, flush raised in BUSY, rdata=0x0000F00D → strobe held until resp, load_valid=0, then IDLE.
- MAX_WAIT=4, lw with no resp → strobes drop after 4 BUSY cycles, bus_error one cycle, stall releases.
- rst asserted mid-BUSY → data_read and stall fall without a clock edge; FSM in IDLE after release.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Memory-stage data access unit: issues one cache access per load/store,
// shifts store lanes, extracts/extends load data and stalls the pipe meanwhile.
module dmem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_resp,
  output logic [1:0]  dbg_state
);

  // Cache handshake: data_read/data_write stay high with stable addr/mbe/wdata
  // from the cycle after the request until the cycle data_resp is seen (or timeout).
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    mbe_q, mbe_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          ld_q, ld_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          flushed_q, flushed_d;
  logic          err_q, err_d;

  logic        active, one_op, legal, aligned, start, trap, timeout;
  logic [3:0]  mbe_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  // Request decode
  always_comb begin
    one_op  = mem_read ^ mem_write;
    active  = req_valid & ~flush & ~rst;
    legal   = 1'b0;
    aligned = 1'b1;
    mbe_c   = 4'b1111;
    wdata_c = store_data;
    if (mem_read) legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else          legal = (funct3 inside {3'b000, 3'b001, 3'b010});
    case (funct3[1:0])
      2'b00: begin
        mbe_c   = 4'b0001 << addr[1:0];
        wdata_c = store_data << {addr[1:0], 3'b000};
      end
      2'b01: begin
        aligned = ~addr[0];
        mbe_c   = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = store_data << {addr[1], 4'b0000};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
    start = active & one_op & legal & aligned;
    trap  = active & (mem_read | mem_write) & ~(one_op & legal & aligned);
  end

  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (MAX_WAIT != 0) && (cnt_inc == CW'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mbe_q     <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ld_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      flushed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mbe_q     <= mbe_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      ld_q      <= ld_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      flushed_q <= flushed_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (data_resp || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state; response beats timeout when both land together
  always_comb begin
    cnt_d     = '0;
    addr_d    = addr_q;
    mbe_d     = mbe_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    ld_d      = ld_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    flushed_d = flushed_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = {addr[31:2], 2'b00};
          mbe_d     = mbe_c;
          wdata_d   = wdata_c;
          read_d    = mem_read;
          write_d   = mem_write;
          ld_d      = mem_read;
          f3_d      = funct3;
          off_d     = addr[1:0];
          flushed_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (flush) flushed_d = 1'b1;
        if (data_resp) begin
          rdata_d = data_rdata;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else if (timeout) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v = rdata_q[{off_q, 3'b000} +: 8];
    half_v = rdata_q[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   ext_v = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
      2'b01:   ext_v = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: ext_v = rdata_q;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    bus_error  = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall      = start;
        misaligned = trap;
      end
      S_BUSY: stall = 1'b1;
      S_DONE: begin
        load_valid = ld_q & ~flushed_q & ~err_q & ~flush;
        bus_error  = err_q;
        if (load_valid) load_data = ext_v;
      end
      default: ;
    endcase
  end

  assign data_read  = read_q;
  assign data_write = write_q;
  assign data_mbe   = mbe_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule
